// File: rtl/uart_control_receiver.sv
// UART receive sequencer: qualifies the start bit on oversampled ticks and pulses
// clear/shift/write to the RX shift register and FIFO, flagging framing and overrun errors.
module uart_control_receiver #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rx_serial,
  input  logic sample_tick,
  input  logic full,
  output logic rx_bit,
  output logic clear,
  output logic shift,
  output logic write,
  output logic framing_error,
  output logic overrun_error,
  output logic rx_busy
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t              state;
  logic [TICK_W-1:0]   tick_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [1:0]          sync_q;
  logic                rx_sync;

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_serial};
    end
  end

  assign rx_sync = sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      rx_bit        <= 1'b1;
      clear         <= 1'b0;
      shift         <= 1'b0;
      write         <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      clear         <= 1'b0;
      shift         <= 1'b0;
      write         <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;

      if (sample_tick) begin
        rx_bit <= rx_sync;
      end

      case (state)
        IDLE: begin
          if (sample_tick && !rx_sync) begin
            state    <= START;
            tick_cnt <= '0;
            rx_busy  <= 1'b1;
          end
        end

        // Re-check the line at mid start bit to reject glitches
        START: begin
          if (sample_tick) begin
            if (tick_cnt == HALF_LAST) begin
              if (rx_sync) begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                clear    <= 1'b1;
                tick_cnt <= '0;
                bit_cnt  <= '0;
                state    <= DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end

        DATA: begin
          if (sample_tick) begin
            if (tick_cnt == FULL_LAST) begin
              shift    <= 1'b1;
              tick_cnt <= '0;
              bit_cnt  <= bit_cnt + BIT_W'(1);
              if (bit_cnt == LAST_BIT) begin
                state <= STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end

        STOP: begin
          if (sample_tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              if (rx_sync) begin
                state   <= IDLE;
                rx_busy <= 1'b0;
                if (full) begin
                  overrun_error <= 1'b1;
                end else begin
                  write <= 1'b1;
                end
              end else begin
                framing_error <= 1'b1;
                state         <= BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end

        // Line held low past the stop bit: wait for it to return high
        BREAK: begin
          if (sample_tick && rx_sync) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
          bit_cnt  <= '0;
          rx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_control_receiver.sv
// Bench for uart_control_receiver: drives whole serial frames and compares the
// logged control pulses against a frame-level model of the expected results.
module tb_uart_control_receiver;

  localparam int unsigned DB = 8;
  localparam int unsigned OS = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx_serial = 1'b1;
  logic sample_tick = 1'b0;
  logic full = 1'b0;
  logic rx_bit, clear, shift, write, framing_error, overrun_error, rx_busy;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int tick_count = 0;
  int tick_period = 4;
  int div = 0;

  typedef struct {
    logic [DB-1:0] data;
    bit            stop;
    bit            full_stop;
    int            tp;
  } frame_t;

  frame_t exp_q[$];
  logic   shift_val[$];
  int     shift_cyc[$];
  int     write_cyc[$];
  int     n_clear = 0, n_write = 0, n_fe = 0, n_oe = 0;

  uart_control_receiver #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_serial     (rx_serial),
    .sample_tick   (sample_tick),
    .full          (full),
    .rx_bit        (rx_bit),
    .clear         (clear),
    .shift         (shift),
    .write         (write),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (sample_tick) tick_count <= tick_count + 1;
  end

  // Baud-tick generator, updated away from the active edge
  always @(negedge clk) begin
    if (div >= tick_period - 1) div = 0;
    else div = div + 1;
    sample_tick = (div == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse logger plus per-pulse invariants
  always @(negedge clk) begin
    if (reset_n) begin
      if (clear) n_clear++;
      if (shift) begin
        shift_val.push_back(rx_bit);
        shift_cyc.push_back(cycle);
      end
      if (write) begin
        n_write++;
        write_cyc.push_back(cycle);
        chk("busy_at_write", 32'(rx_busy), 32'd0);
      end
      if (framing_error) begin
        n_fe++;
        chk("busy_at_framing", 32'(rx_busy), 32'd1);
      end
      if (overrun_error) begin
        n_oe++;
        chk("busy_at_overrun", 32'(rx_busy), 32'd0);
      end
      if ((clear | shift | write | framing_error | overrun_error) == 1'b1)
        chk("pulse_onehot", 32'($countones({clear, shift, write, framing_error, overrun_error})), 32'd1);
    end
  end

  task automatic clear_logs();
    exp_q.delete();
    shift_val.delete();
    shift_cyc.delete();
    write_cyc.delete();
    n_clear = 0; n_write = 0; n_fe = 0; n_oe = 0;
  endtask

  task automatic hold_line(input logic v, input int n);
    int target;
    rx_serial = v;
    target = tick_count + n;
    while (tick_count < target) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input bit stop, input bit full_mid,
                            input bit full_stop, input int stop_ticks);
    frame_t f;
    f.data = d; f.stop = stop; f.full_stop = full_stop; f.tp = tick_period;
    exp_q.push_back(f);
    full = full_mid;
    hold_line(1'b0, OS);
    for (int i = 0; i < int'(DB); i++) hold_line(d[i], OS);
    full = full_stop;
    hold_line(stop, stop_ticks);
  endtask

  // Frame-level model: each frame yields one clear, DB shifts of its data LSB first,
  // spaced one bit period apart, then write / overrun / framing by stop bit and full.
  task automatic check_frames(input string tag);
    int exp_w, exp_oe, exp_fe, k, wi;
    logic [DB-1:0] obs;
    int spacing;
    exp_w = 0; exp_oe = 0; exp_fe = 0;
    foreach (exp_q[j]) begin
      if (!exp_q[j].stop) exp_fe++;
      else if (exp_q[j].full_stop) exp_oe++;
      else exp_w++;
    end
    chk({tag, "_clears"}, n_clear, exp_q.size());
    chk({tag, "_shifts"}, shift_val.size(), exp_q.size() * DB);
    chk({tag, "_writes"}, n_write, exp_w);
    chk({tag, "_overruns"}, n_oe, exp_oe);
    chk({tag, "_framing"}, n_fe, exp_fe);
    if (shift_val.size() == exp_q.size() * DB && write_cyc.size() == exp_w) begin
      k = 0; wi = 0;
      foreach (exp_q[j]) begin
        for (int i = 0; i < int'(DB); i++) obs[i] = shift_val[k + i];
        chk({tag, "_data"}, 32'(obs), 32'(exp_q[j].data));
        spacing = OS * exp_q[j].tp;
        for (int i = 1; i < int'(DB); i++)
          if (shift_cyc[k + i] - shift_cyc[k + i - 1] != OS * exp_q[j].tp)
            spacing = shift_cyc[k + i] - shift_cyc[k + i - 1];
        chk({tag, "_shift_spacing"}, spacing, OS * exp_q[j].tp);
        if (exp_q[j].stop && !exp_q[j].full_stop) begin
          chk({tag, "_write_latency"}, write_cyc[wi] - shift_cyc[k + DB - 1], OS * exp_q[j].tp);
          wi++;
        end
        k += DB;
      end
    end
    clear_logs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DB-1:0] d;
    bit stop, fm, fs;
    int idle;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_rx_bit", 32'(rx_bit), 32'd1);
    chk("reset_pulses", 32'({clear, shift, write, framing_error, overrun_error}), 32'd0);
    chk("reset_busy", 32'(rx_busy), 32'd0);
    reset_n = 1'b1;
    hold_line(1'b1, 2 * OS);

    // Single frame 0xA5, tick every 4 clk
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, OS);
    hold_line(1'b1, OS);
    chk("a5_busy_idle", 32'(rx_busy), 32'd0);
    check_frames("a5");

    // Start-bit glitch
    hold_line(1'b0, 3);
    hold_line(1'b1, 2);
    chk("glitch_busy_mid", 32'(rx_busy), 32'd1);
    hold_line(1'b1, OS);
    chk("glitch_busy_end", 32'(rx_busy), 32'd0);
    check_frames("glitch");

    // Framing error: stop low, line low two bit periods, then high
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 2 * OS);
    chk("fe_busy_low", 32'(rx_busy), 32'd1);
    hold_line(1'b1, OS);
    chk("fe_busy_high", 32'(rx_busy), 32'd0);
    check_frames("fe");

    // Overrun, then full released before the stop bit
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1, OS);
    hold_line(1'b1, OS);
    check_frames("ovr");
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0, OS);
    hold_line(1'b1, OS);
    check_frames("ovr_release");

    // Back-to-back frames with no idle
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, OS);
    send_frame(8'hAA, 1'b1, 1'b0, 1'b0, OS);
    hold_line(1'b1, OS);
    check_frames("b2b");

    // Reset after the 4th shift aborts the frame
    d = 8'h6B;
    hold_line(1'b0, OS);
    for (int i = 0; i < 4; i++) hold_line(d[i], OS);
    reset_n = 1'b0;
    #1;
    chk("abort_pulses", 32'({clear, shift, write, framing_error, overrun_error}), 32'd0);
    chk("abort_busy", 32'(rx_busy), 32'd0);
    chk("abort_rx_bit", 32'(rx_bit), 32'd1);
    chk("abort_clears", n_clear, 1);
    chk("abort_shifts", shift_val.size(), 4);
    chk("abort_writes", n_write, 0);
    clear_logs();
    rx_serial = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    hold_line(1'b1, OS);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, OS);
    hold_line(1'b1, OS);
    chk("abort_no_late_errors", 32'(n_fe + n_oe), 32'd0);
    check_frames("after_abort");

    // sample_tick every clk
    tick_period = 1;
    send_frame(8'(($urandom)), 1'b1, 1'b0, 1'b0, OS);
    hold_line(1'b1, OS);
    check_frames("tick_every_clk");

    // Randomized frames
    for (int n = 0; n < 14; n++) begin
      tick_period = $urandom_range(1, 5);
      d = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      fm = 1'($urandom);
      fs = 1'($urandom);
      send_frame(d, stop, fm, fs, OS);
      idle = stop ? $urandom_range(0, OS) : OS;
      if (idle > 0) hold_line(1'b1, idle);
      check_frames("rand");
    end
    hold_line(1'b1, OS);
    chk("final_busy", 32'(rx_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_control_receiver.md
# uart_control_receiver

Receive-side sequencer of the UART. Watches the serial RX line on a 16x-oversampled tick, detects and qualifies the start bit, and issues one-cycle control pulses to the RX shift register (clear, shift) and the RX FIFO (write). Flags framing and overrun errors. It is the receive counterpart of the transmit controller and drives the same shift-register and FIFO primitives.

## Interface
- DATA_BITS, 8: data bits per frame, LSB first; legal range 5..9.
- OVERSAMPLE, 16: sample_tick pulses per bit period; even, ≥ 4.

- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rx_serial  input  1  raw serial line, idle high; asynchronous to clk.
- sample_tick  input  1  one-clk-wide pulse at OVERSAMPLE x baud, from baud generator.
- full  input  1  RX FIFO full.
- rx_bit  output  1  line value captured at the last sample_tick; data input of the RX shift register.
- clear  output  1  one-cycle pulse; clear RX shift register.
- shift  output  1  one-cycle pulse; shift rx_bit into RX shift register.
- write  output  1  one-cycle pulse; push shift-register contents into RX FIFO.
- framing_error  output  1  one-cycle pulse; stop bit sampled low.
- overrun_error  output  1  one-cycle pulse; valid frame dropped because FIFO full.
- rx_busy  output  1  high whenever state ≠ IDLE.

## Operation
- Synchronizer: rx_serial goes through a 2-flop synchronizer (both flops reset to 1) giving rx_sync. Only rx_sync is used internally.
- rx_bit <= rx_sync on every sample_tick and holds between ticks.
- Counters:
  - tick_cnt: width $clog2(OVERSAMPLE).
  - bit_cnt: width $clog2(DATA_BITS+1).
  - Both reset to 0.
- States: IDLE, START, DATA, STOP, BREAK.
- Logic evaluates only in cycles with sample_tick = 1. Otherwise state and counters hold.
- IDLE:
  - A tick with rx_sync = 0 is the detection tick: go to START with tick_cnt = 0.
- START:
  - On a tick with tick_cnt = OVERSAMPLE/2-1 (the 8th tick after detection), evaluate rx_sync.
  - rx_sync = 1 (glitch): go to IDLE. No pulses.
  - rx_sync = 0: pulse clear, set tick_cnt = 0 and bit_cnt = 0, go to DATA.
  - Any other tick: tick_cnt++.
- DATA:
  - On a tick with tick_cnt = OVERSAMPLE-1: pulse shift, bit_cnt++, tick_cnt = 0.
  - When bit_cnt reaches DATA_BITS on that shift, go to STOP.
  - Any other tick: tick_cnt++.
- STOP:
  - On a tick with tick_cnt = OVERSAMPLE-1, evaluate rx_sync.
  - rx_sync = 1 and full = 0: pulse write, go to IDLE.
  - rx_sync = 1 and full = 1: pulse overrun_error, no write, go to IDLE.
  - rx_sync = 0: pulse framing_error, no write, go to BREAK.
- BREAK: the first tick with rx_sync = 1 returns to IDLE. No pulses.
- full is sampled only at the STOP decision. full changing mid-frame has no effect.
- At most one of clear, shift, write, framing_error and overrun_error is high in any cycle.
- Unreachable state encodings recover to IDLE on the next clk.

## Timing
- Reset values:
  - state IDLE; tick_cnt and bit_cnt 0.
  - Synchronizer flops 1, rx_bit 1.
  - clear, shift, write, framing_error, overrun_error all 0; rx_busy 0.
- All pulse outputs are registered. A pulse is high for exactly one clk, in the cycle immediately after the qualifying sample_tick cycle.
- rx_bit is valid when shift is high: it holds the value sampled at that tick.
- Line-to-detection latency: 2 clk of synchronizer plus wait for the next sample_tick.
- Detection to clear: OVERSAMPLE/2 ticks, +1 clk.
- Successive shift pulses are spaced exactly OVERSAMPLE ticks apart.
- Last shift to write: OVERSAMPLE ticks, +1 clk.
- Back-to-back frames: a start bit immediately following a valid stop bit is detected on the first tick in IDLE. No extra idle time is required.
- sample_tick may be asserted in consecutive clk cycles. Behaviour is identical, only compressed.
- Reset mid-frame aborts immediately. No write or error pulse is produced. The next frame is received normally.

## Test plan
- Receive 0xA5, 8N1, OVERSAMPLE = 16, sample_tick every 4 clk, full = 0:
  - exactly 1 clear, then 8 shift pulses with rx_bit sequence 1,0,1,0,0,1,0,1;
  - shift pulses spaced 64 clk apart;
  - then 1 write;
  - rx_busy falls the cycle after the STOP decision.
- Start-bit glitch: rx_serial low for 3 ticks, then high → no clear, shift or write; state back to IDLE after the 8th tick.
- Framing error: frame 0x3C with stop bit driven low, then line high after 2 bit periods → 8 shifts, framing_error pulse, no write; rx_busy stays high until the first high tick.
- Overrun: full = 1 through frame 0xFF → 8 shifts, overrun_error pulse, no write. Repeating with full toggling 1→0 before STOP → write pulse.
- Back-to-back frames 0x55 then 0xAA with no idle between → 2 clear, 16 shift, 2 write pulses, and the correct rx_bit sequences.
- Reset asserted after the 4th shift of a frame → all outputs 0 immediately; following frame 0x81 is received with 8 shifts and 1 write.
